// File: rtl/bus_master_pkg.sv
// Shared constants for the bus master port: FSM state codes, error codes and
// small state-decoding helpers used by the port and its bench.
package bus_master_pkg;

    typedef logic [2:0] state_t;
    typedef logic [7:0] err_code_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_REQ     = 3'd1;
    localparam state_t ST_ADDR    = 3'd2;
    localparam state_t ST_DATA    = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_ERR     = 3'd5;

    localparam err_code_t ERR_NONE     = 8'h00;
    localparam err_code_t ERR_GNT_TO   = 8'h01;
    localparam err_code_t ERR_ADDR_TO  = 8'h02;
    localparam err_code_t ERR_DATA_TO  = 8'h03;
    localparam err_code_t ERR_GNT_LOST = 8'h04;

    // States in which the arbiter request line is held high.
    function automatic logic holds_bus(input state_t s);
        return (s == ST_REQ) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

    // States in which the address phase is active on the bus.
    function automatic logic addr_phase(input state_t s);
        return (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Shared-bus side of one master port: arbiter request/grant plus the
// AddressValid / TargetReady / DataStrobe transfer handshake.
interface bus_master_if #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 16
);
    logic                 BARQ;
    logic                 BAGD;
    logic                 AddressValid;
    logic [AddrWidth-1:0] bus_addr;
    logic [DataWidth-1:0] bus_wdata;
    logic [DataWidth-1:0] bus_rdata;
    logic                 TargetReady;
    logic                 DataStrobe;

    modport master (
        output BARQ,
        output AddressValid,
        output bus_addr,
        output bus_wdata,
        output DataStrobe,
        input  BAGD,
        input  bus_rdata,
        input  TargetReady
    );

    modport slave (
        input  BARQ,
        input  AddressValid,
        input  bus_addr,
        input  bus_wdata,
        input  DataStrobe,
        output BAGD,
        output bus_rdata,
        output TargetReady
    );
endinterface

// File: rtl/wait_timer.sv
// Handshake wait counter: expired is high during the TimeoutCycles-th
// consecutive enabled cycle since the last synchronous clear.
module wait_timer #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic clrn,
    input  logic sclr,
    input  logic ena,
    output logic expired
);
    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] count;

    // Saturates at the last count so a held expiry never wraps back to idle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (sclr) begin
            count <= '0;
        end else if (ena && (count != LastCount)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = ena && (count == LastCount);

endmodule

// File: rtl/bus_master_port.sv
// Bus master port: accepts a burst command, requests the bus, runs the address
// phase and one strobe per word, and reports handshake faults as a sticky code.
module bus_master_port
    import bus_master_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int LenWidth      = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rnw,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [LenWidth-1:0]  cmd_len,
    input  logic [DataWidth-1:0] wr_data,
    output logic                 wr_next,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_data,
    output logic                 done,
    output logic [7:0]           Error,
    bus_master_if.master         bus
);

    state_t                state;
    state_t                next_state;
    err_code_t             err_next;
    logic                  rnw_q;
    logic [LenWidth-1:0]   len_q;
    logic [LenWidth-1:0]   word_cnt;
    logic [AddrWidth-1:0]  word_addr;
    logic                  last_out;
    logic                  accept;
    logic                  launch;
    logic                  expired;
    logic                  timer_sclr;
    logic                  timer_ena;

    assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign timer_ena  = holds_bus(state);
    assign timer_sclr = (next_state != state) || launch;

    wait_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wait_timer (
        .clk     (clk),
        .clrn    (clrn),
        .sclr    (timer_sclr),
        .ena     (timer_ena),
        .expired (expired)
    );

    // A lost grant outranks a timeout; in DATA the cycle showing the final
    // strobe ends the burst without looking at TargetReady.
    always_comb begin
        next_state = state;
        err_next   = ERR_NONE;
        launch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_REQ;
            end
            ST_REQ: begin
                if (bus.BAGD) begin
                    next_state = ST_ADDR;
                end else if (expired) begin
                    next_state = ST_ERR;
                    err_next   = ERR_GNT_TO;
                end
            end
            ST_ADDR: begin
                if (!bus.BAGD) begin
                    next_state = ST_ERR;
                    err_next   = ERR_GNT_LOST;
                end else if (bus.TargetReady) begin
                    next_state = ST_DATA;
                end else if (expired) begin
                    next_state = ST_ERR;
                    err_next   = ERR_ADDR_TO;
                end
            end
            ST_DATA: begin
                if (!bus.BAGD) begin
                    next_state = ST_ERR;
                    err_next   = ERR_GNT_LOST;
                end else if (last_out) begin
                    next_state = ST_RELEASE;
                end else if (bus.TargetReady) begin
                    launch = 1'b1;
                end else if (expired) begin
                    next_state = ST_ERR;
                    err_next   = ERR_DATA_TO;
                end
            end
            ST_RELEASE: next_state = ST_IDLE;
            ST_ERR:     next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so each one lines up
    // with the cycle its state is actually occupied.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state            <= ST_IDLE;
            cmd_ready        <= 1'b0;
            bus.BARQ         <= 1'b0;
            bus.AddressValid <= 1'b0;
            bus.DataStrobe   <= 1'b0;
            wr_next          <= 1'b0;
            rsp_valid        <= 1'b0;
            done             <= 1'b0;
            Error            <= ERR_NONE;
        end else begin
            state            <= next_state;
            cmd_ready        <= (next_state == ST_IDLE);
            bus.BARQ         <= holds_bus(next_state);
            bus.AddressValid <= addr_phase(next_state);
            bus.DataStrobe   <= launch;
            wr_next          <= launch && !rnw_q;
            rsp_valid        <= launch && rnw_q;
            done             <= (next_state == ST_RELEASE);
            if (accept) begin
                Error <= ERR_NONE;
            end else if (next_state == ST_ERR) begin
                Error <= err_next;
            end
        end
    end

    // Burst datapath: word_addr always holds the address of the next word to
    // launch, bus_addr the address of the word on the bus.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rnw_q         <= 1'b0;
            len_q         <= '0;
            word_cnt      <= '0;
            word_addr     <= '0;
            last_out      <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rsp_data      <= '0;
        end else begin
            if (accept) begin
                rnw_q     <= cmd_rnw;
                len_q     <= cmd_len;
                word_addr <= cmd_addr;
                word_cnt  <= '0;
                last_out  <= 1'b0;
            end
            if (launch) begin
                word_addr     <= word_addr + 1'b1;
                word_cnt      <= word_cnt + 1'b1;
                last_out      <= (word_cnt == len_q);
                bus.bus_addr  <= word_addr;
                bus.bus_wdata <= rnw_q ? '0 : wr_data;
                if (rnw_q) rsp_data <= bus.bus_rdata;
            end else if ((state == ST_REQ) && (next_state == ST_ADDR)) begin
                bus.bus_addr <= word_addr;
            end else if (!addr_phase(next_state)) begin
                bus.bus_addr  <= '0;
                bus.bus_wdata <= '0;
            end
        end
    end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Single-master bus-side port that takes a burst command from local logic, requests the shared bus from the arbiter (one BARQ/BAGD pair), and runs the address phase and data phase with the AddressValid / TargetReady / DataStrobe handshake. One instance per device sits directly upstream of the bus arbiter: its BARQ drives one arbiter request line and its BAGD comes from the matching grant line. Handshake faults (grant/target timeout, grant lost mid-burst) are reported as an 8-bit error code, the same width as one arbiter Error lane.

## Interface
- AddrWidth, 16, bus address width
- DataWidth, 16, bus data width
- LenWidth, 4, burst length field; burst = len+1 words (1..16)
- TimeoutCycles, 255, max wait cycles in any handshake wait before error
- clk  in  1  system clock; all logic on rising edge
- clrn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_rnw  in  1  1 = read burst, 0 = write burst
- cmd_addr  in  AddrWidth  start address
- cmd_len  in  LenWidth  words minus one
- wr_data  in  DataWidth  write word, sampled on the DataStrobe cycle
- wr_next  out  1  pulse: current wr_data consumed, present next word
- rsp_valid  out  1  one-cycle pulse with read word; no backpressure
- rsp_data  out  DataWidth  read word
- done  out  1  one-cycle pulse, burst completed normally
- BARQ  out  1  bus request to arbiter
- BAGD  in  1  bus grant from arbiter
- AddressValid  out  1  address phase active
- bus_addr  out  AddrWidth  current word address
- bus_wdata  out  DataWidth  write data
- bus_rdata  in  DataWidth  read data
- TargetReady  in  1  target ready / word accept
- DataStrobe  out  1  word transfer strobe
- Error  out  8  sticky error code; 8'h00 = none

## Operation
- States: IDLE, REQ, ADDR, DATA, RELEASE, ERR.
- IDLE: cmd_ready=1. On accept: latch rnw/addr/len, clear Error to 8'h00, clear word counter, -> REQ.
- REQ: BARQ=1. BAGD=1 -> ADDR. TimeoutCycles consecutive cycles without BAGD -> ERR, code 8'h01.
- ADDR: BARQ=1, AddressValid=1, bus_addr=latched addr. TargetReady=1 -> DATA. Timeout -> ERR, code 8'h02.
- DATA: BARQ=1, AddressValid=1. Each cycle TargetReady=1: DataStrobe=1 next cycle, one word transferred; write: bus_wdata=wr_data, wr_next=1; read: rsp_data<=bus_rdata, rsp_valid=1. Word counter and bus_addr increment (wrap modulo 2^AddrWidth). TargetReady=0 is a wait state: no strobe, timer runs; timeout -> ERR, code 8'h03. Last word (counter==len) -> RELEASE.
- BAGD=0 sampled in ADDR or DATA -> ERR, code 8'h04 (precedence over timeout in same cycle).
- RELEASE: all bus outputs low for one cycle, done=1 -> IDLE.
- ERR: all bus outputs low, Error latched, -> IDLE next cycle. Error holds until the next command accept.
- Wait timer clears on every state change and every transferred word.

## Timing
- Reset: all outputs 0 (cmd_ready 0 during reset, 1 in the first IDLE cycle after), state IDLE, Error 8'h00.
- All outputs registered.
- Accept at edge N -> BARQ high from N+1. BAGD seen at edge M -> AddressValid from M+1.
- Zero-wait burst of L words: L DataStrobe cycles back-to-back, then one RELEASE cycle; BARQ drops in the RELEASE cycle.
- Minimum gap between bursts: RELEASE + IDLE = 2 cycles with BARQ low; the arbiter sees a deasserted request.
- Reset mid-burst: immediate return to IDLE, all outputs 0, no done, no Error.

## Structure
- Package bus_master_pkg: state enum, error code constants (ERR_NONE, ERR_GNT_TO, ERR_ADDR_TO, ERR_DATA_TO, ERR_GNT_LOST).
- One sub-module: wait_timer (clk, clrn, sclr, ena -> expired at TimeoutCycles), a counter with synchronous clear and enable.

## Test plan
- Write, addr 16'h0100, len 3, BAGD after 2 cycles, TargetReady held 1 -> 4 strobes at 0100..0103, 4 wr_next, done, Error 00.
- Read, len 0, TargetReady low 5 cycles in DATA -> one strobe after wait, rsp_valid with bus_rdata 16'hBEEF, done.
- BAGD never asserted -> ERR after 255 REQ cycles, Error 8'h01, BARQ low, next accept clears Error.
- BAGD dropped after 2 of 4 words -> Error 8'h04, exactly 2 strobes, no done.
- Address 16'hFFFF, len 1 -> bus_addr FFFF then 0000.
- clrn pulsed low mid-DATA -> all outputs 0 asynchronously, IDLE, new burst completes normally.
